ex_hazard_ctrl: RTL and testbench

Pipeline hazard controller that sequences the ID/EX pipeline register and the execute stage. It tracks destinations of in-flight instructions in the EX, MEM and WB slots. It generates PC and IF/ID holds, ID/EX bubble and hold, IF/ID flush, and the EX operand forwarding selects. It also owns a counter that keeps multi-cycle shift operations in EX.

---
 rtl/ex_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl.sv
// Hazard controller for the ID/EX boundary: load-use stall, branch flush,
// multi-cycle shift hold in EX and EX operand forwarding selects.
module ex_hazard_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [2:0] id_src1,
    input  logic [2:0] id_src2,
    input  logic       id_uses_src1,
    input  logic       id_uses_src2,
    input  logic [2:0] id_dst,
    input  logic       id_writes,
    input  logic       id_is_load,
    input  logic       id_is_multi,
    input  logic [7:0] id_shift_count,
    input  logic       ex_branch_taken,
    output logic       pc_hold,
    output logic       ifid_hold,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       idex_hold,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       ex_busy,
    output logic [2:0] busy_cnt
);

    localparam int unsigned RW = 3;
    localparam int unsigned CW = 3;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_e;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] dst;
        logic          writes;
        logic          is_load;
    } slot_t;

    typedef struct packed {
        slot_t         s;
        logic [RW-1:0] src1;
        logic [RW-1:0] src2;
        logic          uses1;
        logic          uses2;
    } ex_slot_t;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    ex_slot_t      ex_q, ex_d;
    slot_t         mem_q, mem_d;
    slot_t         wb_q, wb_d;

    logic          load_use_c;
    logic          pc_hold_c, ifid_hold_c, ifid_flush_c, idex_bubble_c, idex_hold_c;
    logic [1:0]    fwd_a_c, fwd_b_c;
    logic [CW-1:0] id_n_c;
    ex_slot_t      id_slot_c;
    logic          unused_bits;

    // Only the low bits of the shift amount set the extra EX residency.
    assign id_n_c      = id_shift_count[CW-1:0];
    assign unused_bits = ^{id_shift_count[7:CW], wb_q.is_load};

    assign id_slot_c = {1'b1, id_dst, id_writes, id_is_load,
                        id_src1, id_src2, id_uses_src1, id_uses_src2};

    assign load_use_c = id_valid && ex_q.s.valid && ex_q.s.is_load && ex_q.s.writes &&
                        ((id_uses_src1 && (ex_q.s.dst == id_src1)) ||
                         (id_uses_src2 && (ex_q.s.dst == id_src2)));

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic uses, input logic [RW-1:0] src,
                                           input slot_t mem, input slot_t wb);
        logic [1:0] sel;
        sel = FWD_RF;
        if (uses && mem.valid && mem.writes && (mem.dst == src)) begin
            sel = FWD_MEM;
        end else if (uses && wb.valid && wb.writes && (wb.dst == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    assign fwd_a_c = fwd_sel(ex_q.uses1, ex_q.src1, mem_q, wb_q);
    assign fwd_b_c = fwd_sel(ex_q.uses2, ex_q.src2, mem_q, wb_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ex_d          = ex_q;
        mem_d         = mem_q;
        wb_d          = wb_q;
        pc_hold_c     = 1'b0;
        ifid_hold_c   = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        idex_hold_c   = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (load_use_c) begin
                    pc_hold_c     = 1'b1;
                    ifid_hold_c   = 1'b1;
                    idex_bubble_c = 1'b1;
                end
                wb_d  = mem_q;
                mem_d = ex_q.s;
                if (idex_bubble_c || !id_valid) begin
                    ex_d = '0;
                end else begin
                    ex_d = id_slot_c;
                    if (id_is_multi && (id_n_c != '0)) begin
                        state_d = BUSY;
                        cnt_d   = id_n_c;
                    end
                end
            end
            BUSY: begin
                // EX is frozen; the stage behind it drains and MEM gets a bubble.
                pc_hold_c   = 1'b1;
                ifid_hold_c = 1'b1;
                idex_hold_c = 1'b1;
                wb_d        = mem_q;
                mem_d       = '0;
                cnt_d       = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end

    // Controls are forced low while reset is asserted, independent of ID inputs.
    assign pc_hold     = rst_n & pc_hold_c;
    assign ifid_hold   = rst_n & ifid_hold_c;
    assign ifid_flush  = rst_n & ifid_flush_c;
    assign idex_bubble = rst_n & idex_bubble_c;
    assign idex_hold   = rst_n & idex_hold_c;
    assign fwd_a       = rst_n ? fwd_a_c : FWD_RF;
    assign fwd_b       = rst_n ? fwd_b_c : FWD_RF;
    assign ex_busy     = (state_q == BUSY);
    assign busy_cnt    = cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: directed hazard scenarios plus random
// instruction streams checked against an instruction-level pipeline model.
module tb_ex_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       id_valid, id_uses_src1, id_uses_src2, id_writes, id_is_load, id_is_multi;
    logic [2:0] id_src1, id_src2, id_dst;
    logic [7:0] id_shift_count;
    logic       ex_branch_taken;
    logic       pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold, ex_busy;
    logic [1:0] fwd_a, fwd_b;
    logic [2:0] busy_cnt;

    always #5 clk = ~clk;

    ex_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2),
        .id_dst(id_dst), .id_writes(id_writes), .id_is_load(id_is_load),
        .id_is_multi(id_is_multi), .id_shift_count(id_shift_count),
        .ex_branch_taken(ex_branch_taken),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .idex_hold(idex_hold),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_busy(ex_busy), .busy_cnt(busy_cnt)
    );

    typedef struct packed {
        logic       v;
        logic [2:0] dst;
        logic       wr, ld, mul;
        logic [7:0] cnt;
        logic [2:0] s1, s2;
        logic       u1, u2;
    } ins_t;

    typedef struct packed {
        logic       pc, ifid, flush, bub, hold;
        logic [1:0] fa, fb;
        logic       busy;
        logic [2:0] bcnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    // Model: the instruction resident in EX and how many cycles it has spent
    // there, plus the instructions that left EX one and two edges ago.
    ins_t m_ex, m_mem, m_wb;
    int   m_k;
    exp_t last_exp;
    ins_t cur;
    exp_t mon_e, mon_a;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endfunction

    function automatic exp_t dut_vec();
        return {pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold, fwd_a, fwd_b, ex_busy, busy_cnt};
    endfunction

    function automatic logic [1:0] fsel(input logic u, input logic [2:0] s);
        if (u && m_mem.v && m_mem.wr && m_mem.dst == s) return 2'b01;
        if (u && m_wb.v && m_wb.wr && m_wb.dst == s) return 2'b10;
        return 2'b00;
    endfunction

    function automatic exp_t model_eval(input ins_t id, input logic br);
        exp_t e = '0;
        int   n;
        n = (m_ex.v && m_ex.mul) ? int'(m_ex.cnt[2:0]) : 0;
        if (m_k < n) begin
            e.busy = 1'b1; e.bcnt = 3'(n - m_k);
            e.pc = 1'b1; e.ifid = 1'b1; e.hold = 1'b1;
        end else if (br) begin
            e.flush = 1'b1; e.bub = 1'b1;
        end else if (id.v && m_ex.v && m_ex.ld && m_ex.wr &&
                     ((id.u1 && id.s1 == m_ex.dst) || (id.u2 && id.s2 == m_ex.dst))) begin
            e.pc = 1'b1; e.ifid = 1'b1; e.bub = 1'b1;
        end
        e.fa = fsel(m_ex.u1, m_ex.s1);
        e.fb = fsel(m_ex.u2, m_ex.s2);
        return e;
    endfunction

    function automatic void model_step(input ins_t id, input exp_t e);
        m_wb = m_mem;
        if (e.busy) begin
            m_k++;
            m_mem = '0;
        end else begin
            m_mem = m_ex;
            m_k   = 0;
            m_ex  = (e.bub || !id.v) ? '0 : id;
        end
    endfunction

    function automatic void model_reset();
        m_ex = '0; m_mem = '0; m_wb = '0; m_k = 0; last_exp = '0;
    endfunction

    function automatic ins_t mk(input logic [2:0] dst, input logic wr, input logic ld,
                                input logic mul, input logic [7:0] cnt,
                                input logic [2:0] s1, input logic u1,
                                input logic [2:0] s2, input logic u2);
        return {1'b1, dst, wr, ld, mul, cnt, s1, s2, u1, u2};
    endfunction

    function automatic ins_t rand_ins();
        ins_t r;
        r.v   = ($urandom_range(0, 99) < 85);
        r.dst = 3'($urandom_range(0, 3));
        r.wr  = ($urandom_range(0, 99) < 80);
        r.ld  = ($urandom_range(0, 99) < 30);
        r.mul = !r.ld && ($urandom_range(0, 99) < 15);
        r.cnt = 8'($urandom);
        r.s1  = 3'($urandom_range(0, 3));
        r.s2  = 3'($urandom_range(0, 3));
        r.u1  = 1'($urandom_range(0, 1));
        r.u2  = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic drive(input ins_t id, input logic br);
        id_valid = id.v; id_dst = id.dst; id_writes = id.wr; id_is_load = id.ld;
        id_is_multi = id.mul; id_shift_count = id.cnt; id_src1 = id.s1; id_src2 = id.s2;
        id_uses_src1 = id.u1; id_uses_src2 = id.u2; ex_branch_taken = br;
    endtask

    // One cycle: drive ID after the edge, queue the model's expectation, advance the model.
    task automatic cyc(input ins_t id, input logic br);
        exp_t e;
        @(posedge clk); #1;
        drive(id, br);
        e = model_eval(id, br);
        sb_q.push_back(e);
        model_step(id, e);
        last_exp = e;
        cur = id;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        drive('0, 1'b0);
        model_reset();
        #1;
        chk("rst_ctrl", {pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold}, 5'b0);
        chk("rst_fwd", {fwd_a, fwd_b}, 4'b0);
        chk("rst_busy", {ex_busy, busy_cnt}, 4'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            mon_a = dut_vec();
            chk("pc_hold", 32'(mon_a.pc), 32'(mon_e.pc));
            chk("ifid_hold", 32'(mon_a.ifid), 32'(mon_e.ifid));
            chk("ifid_flush", 32'(mon_a.flush), 32'(mon_e.flush));
            chk("idex_bubble", 32'(mon_a.bub), 32'(mon_e.bub));
            chk("idex_hold", 32'(mon_a.hold), 32'(mon_e.hold));
            chk("fwd_a", 32'(mon_a.fa), 32'(mon_e.fa));
            chk("fwd_b", 32'(mon_a.fb), 32'(mon_e.fb));
            chk("ex_busy", 32'(mon_a.busy), 32'(mon_e.busy));
            chk("busy_cnt", 32'(mon_a.bcnt), 32'(mon_e.bcnt));
        end
    end

    initial begin
        ins_t ld3, add3, w2a, w2b, rd2, w1, mul3, cons, mul5, mul2, id;
        logic br;
        drive('0, 1'b0);
        model_reset();
        #2;
        do_reset();
        idle(3);

        ld3  = mk(3'd3, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
        add3 = mk(3'd5, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3, 1'b1, 3'd0, 1'b0);
        cyc(ld3, 1'b0);
        cyc(add3, 1'b0);
        #2 chk("lu_stall", {pc_hold, ifid_hold, idex_bubble}, 3'b111);
        cyc(add3, 1'b0);
        #2 chk("lu_release", {pc_hold, idex_bubble}, 2'b00);
        idle(1);
        #2 chk("lu_fwd_wb", 32'(fwd_a), 32'd2);
        idle(3);

        w2a = mk(3'd2, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
        w2b = w2a;
        rd2 = mk(3'd6, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 3'd2, 1'b1);
        cyc(w2a, 1'b0); cyc(w2b, 1'b0); cyc(rd2, 1'b0); idle(1);
        #2 chk("fwd_mem_wins", 32'(fwd_b), 32'd1);
        idle(3);
        w2b.wr = 1'b0;
        cyc(w2a, 1'b0); cyc(w2b, 1'b0); cyc(rd2, 1'b0); idle(1);
        #2 chk("fwd_wb_only", 32'(fwd_b), 32'd2);
        idle(3);
        rd2.u2 = 1'b0;
        cyc(w2a, 1'b0); cyc(w2a, 1'b0); cyc(rd2, 1'b0); idle(1);
        #2 chk("fwd_unused", 32'(fwd_b), 32'd0);
        idle(3);

        w1   = mk(3'd1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
        mul3 = mk(3'd4, 1'b1, 1'b0, 1'b1, 8'h0B, 3'd1, 1'b1, 3'd0, 1'b0);
        cons = mk(3'd5, 1'b1, 1'b0, 1'b0, 8'h00, 3'd4, 1'b1, 3'd0, 1'b0);
        cyc(w1, 1'b0); cyc(mul3, 1'b0);
        cyc(cons, 1'b0);
        #2 chk("mul_c3", {ex_busy, busy_cnt, pc_hold, idex_hold, fwd_a}, {1'b1, 3'd3, 2'b11, 2'b01});
        cyc(cons, 1'b0);
        #2 chk("mul_c2", {ex_busy, busy_cnt, fwd_a}, {1'b1, 3'd2, 2'b10});
        cyc(cons, 1'b0);
        #2 chk("mul_c1", {ex_busy, busy_cnt, fwd_a}, {1'b1, 3'd1, 2'b00});
        cyc(cons, 1'b0);
        #2 chk("mul_run", {ex_busy, busy_cnt, pc_hold}, {1'b0, 3'd0, 1'b0});
        idle(1);
        #2 chk("mul_in_mem", 32'(fwd_a), 32'd1);
        idle(3);

        cyc(ld3, 1'b0);
        cyc(add3, 1'b1);
        #2 chk("br_beats_lu", {ifid_flush, idex_bubble, pc_hold, ifid_hold}, 4'b1100);
        idle(3);

        mul5 = mk(3'd4, 1'b1, 1'b0, 1'b1, 8'hFD, 3'd0, 1'b0, 3'd0, 1'b0);
        mul2 = mk(3'd6, 1'b1, 1'b0, 1'b1, 8'h02, 3'd0, 1'b0, 3'd0, 1'b0);
        cyc(mul5, 1'b0); idle(3);
        #2 chk("mul5_c3", {ex_busy, busy_cnt}, {1'b1, 3'd3});
        do_reset();
        cyc(mul2, 1'b0); idle(1);
        #2 chk("post_rst_issue", {ex_busy, busy_cnt}, {1'b1, 3'd2});
        idle(4);

        for (int i = 0; i < 600; i++) begin
            if (last_exp.pc) begin
                id = cur;
            end else begin
                id = rand_ins();
                if (last_exp.flush) id.v = 1'b0;
            end
            br = ($urandom_range(0, 99) < 8);
            cyc(id, br);
            if (i == 300) begin
                #2 do_reset();
            end
        end
        idle(4);
        @(negedge clk); #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
